// File: rtl/demux_tdm_4_4_if.sv
// Nibble-stream and demultiplexed-channel bundle for demux_tdm_4_4.
// The master drives the TDM stream and reads the channels; the slave is the demultiplexer.
interface demux_tdm_4_4_if;
    logic       inSinc;
    logic       inValido;
    logic [3:0] inDado;
    logic [3:0] outA;
    logic [3:0] outB;
    logic [3:0] outC;
    logic [3:0] outD;
    logic       outValido;
    logic       outErro;
    logic [1:0] outSlot;
    logic       outTravado;

    modport master (
        output inSinc, inValido, inDado,
        input  outA, outB, outC, outD, outValido, outErro, outSlot, outTravado
    );

    modport slave (
        input  inSinc, inValido, inDado,
        output outA, outB, outC, outD, outValido, outErro, outSlot, outTravado
    );
endinterface

// File: rtl/demux_tdm_4_4.sv
// Four-slot TDM nibble demultiplexer: locks on frame sync, collects slots 0..2 in shadow
// registers and commits all four channels together when the slot-3 nibble arrives.
module demux_tdm_4_4 #(
    parameter int TIMEOUT = 8
) (
    input  logic              clock,
    input  logic              reset,
    demux_tdm_4_4_if.slave    bus
);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    typedef enum logic {BUSCA, RECEBE} estado_t;

    estado_t             estado, proxEstado;
    logic [1:0]          slot, proxSlot;
    logic [IDLE_W-1:0]   idleCnt, proxIdle, idleInc;

    logic [3:0]          shA, shB, shC;
    logic                wrShadow;
    logic [1:0]          wrIdx;

    logic [3:0]          regA, regB, regC, regD;
    logic                commit, erro;
    logic                valReg, errReg;

    always_ff @(posedge clock) begin
        if (reset) begin
            estado  <= BUSCA;
            slot    <= 2'd0;
            idleCnt <= '0;
        end else begin
            estado  <= proxEstado;
            slot    <= proxSlot;
            idleCnt <= proxIdle;
        end
    end

    assign idleInc = idleCnt + 1'b1;

    // Framing decisions for the nibble (or idle cycle) sampled at this edge.
    always_comb begin
        proxEstado = estado;
        proxSlot   = slot;
        proxIdle   = idleCnt;
        wrShadow   = 1'b0;
        wrIdx      = 2'd0;
        commit     = 1'b0;
        erro       = 1'b0;

        unique case (estado)
            BUSCA: begin
                proxIdle = '0;
                if (bus.inValido && bus.inSinc) begin
                    wrShadow   = 1'b1;
                    wrIdx      = 2'd0;
                    proxSlot   = 2'd1;
                    proxEstado = RECEBE;
                end
            end
            RECEBE: begin
                if (bus.inValido) begin
                    proxIdle = '0;
                    if (slot == 2'd0) begin
                        if (bus.inSinc) begin
                            wrShadow = 1'b1;
                            wrIdx    = 2'd0;
                            proxSlot = 2'd1;
                        end else begin
                            erro       = 1'b1;
                            proxEstado = BUSCA;
                        end
                    end else if (bus.inSinc) begin
                        // Early sync: the new nibble restarts the frame as slot 0.
                        erro     = 1'b1;
                        wrShadow = 1'b1;
                        wrIdx    = 2'd0;
                        proxSlot = 2'd1;
                    end else if (slot == 2'd3) begin
                        commit   = 1'b1;
                        proxSlot = 2'd0;
                    end else begin
                        wrShadow = 1'b1;
                        wrIdx    = slot;
                        proxSlot = slot + 2'd1;
                    end
                end else if (slot != 2'd0) begin
                    if (idleInc == IDLE_W'(TIMEOUT)) begin
                        erro       = 1'b1;
                        proxSlot   = 2'd0;
                        proxIdle   = '0;
                        proxEstado = BUSCA;
                    end else begin
                        proxIdle = idleInc;
                    end
                end
            end
            default: proxEstado = BUSCA;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            shA <= 4'd0;
            shB <= 4'd0;
            shC <= 4'd0;
        end else if (wrShadow) begin
            unique case (wrIdx)
                2'd0:    shA <= bus.inDado;
                2'd1:    shB <= bus.inDado;
                default: shC <= bus.inDado;
            endcase
        end
    end

    // Commit stage: channels change only on a complete frame, one clock after slot 3.
    always_ff @(posedge clock) begin
        if (reset) begin
            regA   <= 4'd0;
            regB   <= 4'd0;
            regC   <= 4'd0;
            regD   <= 4'd0;
            valReg <= 1'b0;
            errReg <= 1'b0;
        end else begin
            valReg <= commit;
            errReg <= erro;
            if (commit) begin
                regA <= shA;
                regB <= shB;
                regC <= shC;
                regD <= bus.inDado;
            end
        end
    end

    assign bus.outA       = regA;
    assign bus.outB       = regB;
    assign bus.outC       = regC;
    assign bus.outD       = regD;
    assign bus.outValido  = valReg;
    assign bus.outErro    = errReg;
    assign bus.outSlot    = slot;
    assign bus.outTravado = (estado == RECEBE);

    pulsosExclusivos: assert property (@(posedge clock) !(valReg && errReg));

endmodule
